// File: rtl/uart_pkg.sv
// Shared UART definitions: FSM state encoding, parity mode codes and the data-bit clamp.
package uart_pkg;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP,
        BREAK,
        MARK
    } uart_state_t;

    localparam logic [1:0] PAR_NONE = 2'b00;
    localparam logic [1:0] PAR_EVEN = 2'b01;
    localparam logic [1:0] PAR_ODD  = 2'b10;

    localparam int unsigned MIN_DATA_BITS = 5;

    // Requested word length forced into the supported MIN_DATA_BITS..max_bits window.
    function automatic logic [3:0] clamp_data_bits(input logic [3:0]  cfg,
                                                   input int unsigned max_bits);
        logic [3:0] n;
        if (cfg < 4'(MIN_DATA_BITS)) begin
            n = 4'(MIN_DATA_BITS);
        end else if (cfg > 4'(max_bits)) begin
            n = 4'(max_bits);
        end else begin
            n = cfg;
        end
        return n;
    endfunction

endpackage

// File: rtl/uart_tx_fifo.sv
// Synchronous FIFO with a registered not-full flag and occupancy count.
// level_nxt exposes the occupancy that will be loaded at the next edge.
module uart_tx_fifo #(
    parameter int WIDTH = 9,
    parameter int DEPTH = 8,
    parameter int LVL_W = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic [WIDTH-1:0] wdata,
    input  logic             pop,
    output logic [WIDTH-1:0] rdata,
    output logic             ready,
    output logic             empty,
    output logic [LVL_W-1:0] level,
    output logic [LVL_W-1:0] level_nxt
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [LVL_W-1:0] level_q, level_d;
    logic             ready_q, ready_d;
    logic             push_ok, pop_ok;

    // A push is gated by the registered ready, so a same-edge pop can never open a full FIFO.
    always_comb begin
        push_ok  = push && ready_q;
        pop_ok   = pop && (level_q != '0);
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        level_d  = level_q;
        if (push_ok) wr_ptr_d = wr_ptr_q + AW'(1);
        if (pop_ok)  rd_ptr_d = rd_ptr_q + AW'(1);
        case ({push_ok, pop_ok})
            2'b10:   level_d = level_q + LVL_W'(1);
            2'b01:   level_d = level_q - LVL_W'(1);
            default: level_d = level_q;
        endcase
        ready_d = (level_d != LVL_W'(DEPTH));
    end

    always_ff @(posedge clk) begin
        if (push_ok) mem_q[wr_ptr_q] <= wdata;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
            ready_q  <= 1'b1;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            level_q  <= level_d;
            ready_q  <= ready_d;
        end
    end

    assign rdata     = mem_q[rd_ptr_q];
    assign ready     = ready_q;
    assign empty     = (level_q == '0);
    assign level     = level_q;
    assign level_nxt = level_d;

endmodule

// File: rtl/uart_tx_cfg.sv
// UART transmitter with runtime frame format (5..MAX data bits, parity, 1/2 stop) and TX FIFO.
// Line-break generation (BREAK/MARK states) is built only when UART_TX_BREAK_EN is defined.
module uart_tx_cfg
    import uart_pkg::*;
#(
    parameter int MAX_DATA_BITS  = 9,
    parameter int FIFO_DEPTH     = 8,
    parameter int BAUD_DIV_WIDTH = 16
) (
    input  logic                               clk,
    input  logic                               rst_n,
    input  logic [MAX_DATA_BITS-1:0]           tx_data,
    input  logic                               tx_valid,
    output logic                               tx_ready,
    input  logic [BAUD_DIV_WIDTH-1:0]          baud_div,
    input  logic [3:0]                         cfg_data_bits,
    input  logic [1:0]                         cfg_parity,
    input  logic                               cfg_stop2,
    input  logic                               break_req,
    output logic [$clog2(FIFO_DEPTH+1)-1:0]    fifo_level,
    output logic                               busy,
    output logic                               tx
);

    localparam int LVL_W = $clog2(FIFO_DEPTH + 1);

    logic [MAX_DATA_BITS-1:0] fifo_rdata;
    logic                     fifo_empty;
    logic                     fifo_pop;
    logic [LVL_W-1:0]         fifo_level_nxt;

    uart_tx_fifo #(
        .WIDTH (MAX_DATA_BITS),
        .DEPTH (FIFO_DEPTH),
        .LVL_W (LVL_W)
    ) u_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (tx_valid),
        .wdata     (tx_data),
        .pop       (fifo_pop),
        .rdata     (fifo_rdata),
        .ready     (tx_ready),
        .empty     (fifo_empty),
        .level     (fifo_level),
        .level_nxt (fifo_level_nxt)
    );

    uart_state_t               state_q, state_d;
    logic [BAUD_DIV_WIDTH-1:0] cnt_q, cnt_d;
    logic [BAUD_DIV_WIDTH-1:0] div_q, div_d;
    logic [3:0]                bit_idx_q, bit_idx_d;
    logic [3:0]                nbits_q, nbits_d;
    logic [MAX_DATA_BITS-1:0]  shift_q, shift_d;
    logic                      par_en_q, par_en_d;
    logic                      par_bit_q, par_bit_d;
    logic                      stop2_q, stop2_d;
    logic                      stop_idx_q, stop_idx_d;
    logic                      tx_q, tx_d;
    logic                      busy_q, busy_d;

    logic [BAUD_DIV_WIDTH-1:0] eff_div;
    logic [3:0]                cfg_nbits;
    logic [MAX_DATA_BITS-1:0]  data_mask;
    logic                      cfg_par_en, cfg_par_odd;
    logic                      bit_end, start_frame;

    // Frame format as it would be latched if a frame started this cycle.
    always_comb begin
        eff_div   = (baud_div == '0) ? BAUD_DIV_WIDTH'(1) : baud_div;
        cfg_nbits = clamp_data_bits(cfg_data_bits, MAX_DATA_BITS);
        data_mask = '0;
        for (int i = 0; i < MAX_DATA_BITS; i++) begin
            data_mask[i] = (i < int'(cfg_nbits));
        end
        case (cfg_parity)
            PAR_EVEN: begin cfg_par_en = 1'b1; cfg_par_odd = 1'b0; end
            PAR_ODD:  begin cfg_par_en = 1'b1; cfg_par_odd = 1'b1; end
            default:  begin cfg_par_en = 1'b0; cfg_par_odd = 1'b0; end
        endcase
    end

    assign bit_end = (cnt_q == div_q - BAUD_DIV_WIDTH'(1));

`ifndef UART_TX_BREAK_EN
    logic unused_break_req;
    assign unused_break_req = break_req;
`endif

    always_comb begin
        state_d     = state_q;
        cnt_d       = bit_end ? '0 : cnt_q + BAUD_DIV_WIDTH'(1);
        div_d       = div_q;
        bit_idx_d   = bit_idx_q;
        nbits_d     = nbits_q;
        shift_d     = shift_q;
        par_en_d    = par_en_q;
        par_bit_d   = par_bit_q;
        stop2_d     = stop2_q;
        stop_idx_d  = stop_idx_q;
        tx_d        = tx_q;
        start_frame = 1'b0;

        case (state_q)
            IDLE: begin
                cnt_d = '0;
`ifdef UART_TX_BREAK_EN
                if (break_req) begin
                    state_d = BREAK;
                    tx_d    = 1'b0;
                    div_d   = eff_div;
                end else if (!fifo_empty) begin
                    start_frame = 1'b1;
                end
`else
                if (!fifo_empty) start_frame = 1'b1;
`endif
            end
            START: begin
                if (bit_end) begin
                    state_d   = DATA;
                    tx_d      = shift_q[0];
                    bit_idx_d = '0;
                end
            end
            DATA: begin
                if (bit_end) begin
                    if (bit_idx_q == nbits_q - 4'd1) begin
                        if (par_en_q) begin
                            state_d = PARITY;
                            tx_d    = par_bit_q;
                        end else begin
                            state_d    = STOP;
                            tx_d       = 1'b1;
                            stop_idx_d = 1'b0;
                        end
                    end else begin
                        shift_d   = shift_q >> 1;
                        tx_d      = shift_q[1];
                        bit_idx_d = bit_idx_q + 4'd1;
                    end
                end
            end
            PARITY: begin
                if (bit_end) begin
                    state_d    = STOP;
                    tx_d       = 1'b1;
                    stop_idx_d = 1'b0;
                end
            end
            STOP: begin
                // The final stop bit hands straight over to the next start bit when data waits.
                if (bit_end) begin
                    if (stop2_q && !stop_idx_q) begin
                        stop_idx_d = 1'b1;
                    end else if (!fifo_empty) begin
                        start_frame = 1'b1;
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
`ifdef UART_TX_BREAK_EN
            BREAK: begin
                cnt_d = '0;
                if (!break_req) begin
                    state_d = MARK;
                    tx_d    = 1'b1;
                end
            end
            MARK: begin
                if (bit_end) state_d = IDLE;
            end
`endif
            default: begin
                state_d = IDLE;
                tx_d    = 1'b1;
            end
        endcase

        if (start_frame) begin
            state_d    = START;
            tx_d       = 1'b0;
            cnt_d      = '0;
            div_d      = eff_div;
            nbits_d    = cfg_nbits;
            shift_d    = fifo_rdata;
            par_en_d   = cfg_par_en;
            par_bit_d  = (^(fifo_rdata & data_mask)) ^ cfg_par_odd;
            stop2_d    = cfg_stop2;
            stop_idx_d = 1'b0;
            bit_idx_d  = '0;
        end

        fifo_pop = start_frame;
        busy_d   = (state_d != IDLE) || (fifo_level_nxt != '0);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            div_q      <= BAUD_DIV_WIDTH'(1);
            bit_idx_q  <= '0;
            nbits_q    <= 4'(MIN_DATA_BITS);
            shift_q    <= '0;
            par_en_q   <= 1'b0;
            par_bit_q  <= 1'b0;
            stop2_q    <= 1'b0;
            stop_idx_q <= 1'b0;
            tx_q       <= 1'b1;
            busy_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            div_q      <= div_d;
            bit_idx_q  <= bit_idx_d;
            nbits_q    <= nbits_d;
            shift_q    <= shift_d;
            par_en_q   <= par_en_d;
            par_bit_q  <= par_bit_d;
            stop2_q    <= stop2_d;
            stop_idx_q <= stop_idx_d;
            tx_q       <= tx_d;
            busy_q     <= busy_d;
        end
    end

    assign tx   = tx_q;
    assign busy = busy_q;

endmodule

// File: tb/tb_uart_tx_cfg.sv
// Bench for uart_tx_cfg: the driver queues each expected frame, a monitor decodes tx and compares.
module tb_uart_tx_cfg;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic [8:0]  tx_data = '0;
    logic        tx_valid = 1'b0;
    logic        tx_ready;
    logic [15:0] baud_div = 16'd4;
    logic [3:0]  cfg_data_bits = 4'd8;
    logic [1:0]  cfg_parity = 2'b00;
    logic        cfg_stop2 = 1'b0;
    logic        break_req = 1'b0;
    logic [3:0]  fifo_level;
    logic        busy;
    logic        tx;

    uart_tx_cfg #(
        .MAX_DATA_BITS  (9),
        .FIFO_DEPTH     (8),
        .BAUD_DIV_WIDTH (16)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .tx_data       (tx_data),
        .tx_valid      (tx_valid),
        .tx_ready      (tx_ready),
        .baud_div      (baud_div),
        .cfg_data_bits (cfg_data_bits),
        .cfg_parity    (cfg_parity),
        .cfg_stop2     (cfg_stop2),
        .break_req     (break_req),
        .fifo_level    (fifo_level),
        .busy          (busy),
        .tx            (tx)
    );

    always #5 clk = ~clk;

    // seq[t] is the line level during bit time t of the frame (t = 0 is the start bit).
    typedef struct {
        logic [15:0] seq;
        int          n;
        int          div;
        bit          b2b;
    } frame_t;

    frame_t exp_q[$];
    int     tests_run = 0;
    int     fails = 0;
    bit     mon_en = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests_run++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic fail_now(input string name);
        tests_run++;
        fails++;
        $display("FAIL %s: bound expired at %0t", name, $time);
    endtask

    // Literal written in time order, first bit on the left.
    function automatic frame_t from_lit(input logic [15:0] lit, input int n, input int div,
                                        input bit b2b);
        frame_t f;
        f.seq = '0;
        f.n   = n;
        f.div = div;
        f.b2b = b2b;
        for (int t = 0; t < n; t++) f.seq[t] = lit[n-1-t];
        return f;
    endfunction

    function automatic frame_t make_frame(input logic [8:0] d, input int nb, input logic [1:0] par,
                                          input bit s2, input int div, input bit b2b);
        frame_t f;
        int     t;
        logic   p;
        f.seq = '0;
        f.div = div;
        f.b2b = b2b;
        p = 1'b0;
        t = 1;
        for (int i = 0; i < nb; i++) begin
            f.seq[t] = d[i];
            p = p ^ d[i];
            t++;
        end
        if (par == 2'b01) begin f.seq[t] = p;  t++; end
        if (par == 2'b10) begin f.seq[t] = ~p; t++; end
        f.seq[t] = 1'b1; t++;
        if (s2) begin f.seq[t] = 1'b1; t++; end
        f.n = t;
        return f;
    endfunction

    task automatic set_cfg(input int nb, input logic [1:0] par, input bit s2, input int div);
        cfg_data_bits = 4'(nb);
        cfg_parity    = par;
        cfg_stop2     = s2;
        baud_div      = 16'(div);
    endtask

    task automatic push_word(input logic [8:0] d);
        int waited;
        waited = 0;
        @(negedge clk);
        tx_data  = d;
        tx_valid = 1'b1;
        while (tx_ready !== 1'b1 && waited < 500) begin
            @(negedge clk);
            waited++;
        end
        if (tx_ready !== 1'b1) begin
            fail_now("push_timeout");
            tx_valid = 1'b0;
        end else begin
            @(posedge clk);
        end
    endtask

    task automatic release_bus();
        @(negedge clk);
        tx_valid = 1'b0;
    endtask

    task automatic wait_idle(input int limit);
        int n;
        n = 0;
        while (!(busy === 1'b0 && exp_q.size() == 0) && n < limit) begin
            @(negedge clk);
            n++;
        end
        if (n >= limit) fail_now("idle_timeout");
        repeat (2) @(negedge clk);
    endtask

    // Monitor: a low line at a falling clock edge is the first clock of a start bit.
    initial begin : monitor
        frame_t      e;
        logic [15:0] act;
        int          bad;
        bit          aborted;
        forever begin
            @(negedge clk);
            while (mon_en && tx === 1'b0) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_frame", 32'(exp_q.size()), 32'd1);
                    while (mon_en && tx === 1'b0) @(negedge clk);
                end else begin
                    e = exp_q.pop_front();
                    act = '0;
                    bad = 0;
                    aborted = 1'b0;
                    for (int b = 0; b < e.n && !aborted; b++) begin
                        for (int c = 0; c < e.div && !aborted; c++) begin
                            if (b != 0 || c != 0) @(negedge clk);
                            if (!mon_en) aborted = 1'b1;
                            if (c == 0) act[b] = tx;
                            if (tx !== e.seq[b]) bad++;
                        end
                    end
                    if (!aborted) begin
                        check("frame_bits", 32'(act), 32'(e.seq));
                        check("frame_bit_hold", 32'(bad), 32'd0);
                        @(negedge clk);
                        if (e.b2b) begin
                            check("b2b_next_start", 32'(tx), 32'd0);
                        end else begin
                            check("idle_after_stop", 32'(tx), 32'd1);
                            check("busy_drop", 32'(busy), 32'd0);
                        end
                    end
                end
            end
        end
    end

    initial begin : watchdog
        #400000;
        $display("FAIL watchdog: simulation did not complete at %0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin : stimulus
        int low;
        #3 rst_n = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_tx", 32'(tx), 32'd1);
        check("rst_tx_ready", 32'(tx_ready), 32'd1);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_fifo_level", 32'(fifo_level), 32'd0);
        rst_n  = 1'b1;
        mon_en = 1'b1;
        repeat (2) @(negedge clk);

        // 8N1, div 4, 0xA5, plus first-frame latency
        set_cfg(8, 2'b00, 1'b0, 4);
        exp_q.push_back(from_lit(16'b0101001011, 10, 4, 1'b0));
        push_word(9'h0A5);
        release_bus();
        check("lat_edge_n_tx", 32'(tx), 32'd1);
        check("level_after_push", 32'(fifo_level), 32'd1);
        check("busy_after_push", 32'(busy), 32'd1);
        @(negedge clk);
        check("lat_edge_n1_tx", 32'(tx), 32'd0);
        check("level_after_pop", 32'(fifo_level), 32'd0);
        wait_idle(300);

        // 7E2, div 3, 0x03
        set_cfg(7, 2'b01, 1'b1, 3);
        exp_q.push_back(from_lit(16'b01100000011, 11, 3, 1'b0));
        push_word(9'h003);
        release_bus();
        wait_idle(300);

        // 9O1, div 2, 0x1FF: 12 bits x 2 clocks = 24 clocks
        set_cfg(9, 2'b10, 1'b0, 2);
        exp_q.push_back(from_lit(16'b011111111101, 12, 2, 1'b0));
        push_word(9'h1FF);
        release_bus();
        wait_idle(300);

        // data bits below 5 clamp to 5, parity 11 means none, baud_div 0 means 1, MSBs ignored
        set_cfg(3, 2'b11, 1'b0, 0);
        exp_q.push_back(from_lit(16'b0011011, 7, 1, 1'b0));
        push_word(9'h036);
        release_bus();
        wait_idle(300);

        // data bits above 9 clamp to 9, even parity, div 1
        set_cfg(15, 2'b01, 1'b0, 1);
        exp_q.push_back(from_lit(16'b010101010111, 12, 1, 1'b0));
        push_word(9'h155);
        release_bus();
        wait_idle(300);

        // lead frame keeps the shifter busy while 9 more words arrive back-to-back
        set_cfg(8, 2'b00, 1'b0, 2);
        exp_q.push_back(make_frame(9'h0C3, 8, 2'b00, 1'b0, 2, 1'b1));
        for (int i = 1; i <= 9; i++) begin
            exp_q.push_back(make_frame(9'(8'h30 + i), 8, 2'b00, 1'b0, 2, i != 9));
        end
        push_word(9'h0C3);
        for (int i = 1; i <= 8; i++) push_word(9'(8'h30 + i));
        @(negedge clk);
        check("ready_low_when_full", 32'(tx_ready), 32'd0);
        check("level_full", 32'(fifo_level), 32'd8);
        tx_data = 9'h039;
        push_word(9'h039);
        release_bus();
        wait_idle(1000);

        // parity change mid-frame applies only to the following frame
        set_cfg(8, 2'b01, 1'b0, 2);
        exp_q.push_back(make_frame(9'h001, 8, 2'b01, 1'b0, 2, 1'b1));
        exp_q.push_back(make_frame(9'h001, 8, 2'b10, 1'b0, 2, 1'b0));
        push_word(9'h001);
        push_word(9'h001);
        release_bus();
        repeat (6) @(negedge clk);
        cfg_parity = 2'b10;
        wait_idle(300);

`ifdef UART_TX_BREAK_EN
        // break held 20 clocks, then one mark bit time of latched baud_div
        mon_en = 1'b0;
        set_cfg(8, 2'b00, 1'b0, 3);
        @(negedge clk);
        break_req = 1'b1;
        low = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (tx === 1'b0) low++;
        end
        break_req = 1'b0;
        check("break_low_clocks", 32'(low), 32'd20);
        check("break_busy", 32'(busy), 32'd1);
        @(negedge clk);
        check("mark_high", 32'(tx), 32'd1);
        check("mark_busy", 32'(busy), 32'd1);
        repeat (3) @(negedge clk);
        check("mark_done_busy", 32'(busy), 32'd0);
        mon_en = 1'b1;
`endif

        // reset in the middle of DATA
        mon_en = 1'b0;
        set_cfg(8, 2'b00, 1'b0, 4);
        push_word(9'h000);
        push_word(9'h000);
        push_word(9'h000);
        release_bus();
        repeat (8) @(negedge clk);
        check("pre_reset_tx_low", 32'(tx), 32'd0);
        check("pre_reset_level", 32'(fifo_level), 32'd2);
        #2 rst_n = 1'b0;
        #1;
        check("async_rst_tx", 32'(tx), 32'd1);
        check("async_rst_level", 32'(fifo_level), 32'd0);
        check("async_rst_ready", 32'(tx_ready), 32'd1);
        check("async_rst_busy", 32'(busy), 32'd0);
        exp_q.delete();
        @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        mon_en = 1'b1;

        // transmitter recovers cleanly after reset
        set_cfg(5, 2'b00, 1'b0, 1);
        exp_q.push_back(from_lit(16'b0111111, 7, 1, 1'b0));
        push_word(9'h01F);
        release_bus();
        wait_idle(300);

        $display("[TB] %0d tests run, %0d failed", tests_run, fails);
        $finish;
    end

endmodule
